// File: rtl/riscv_lsu_pipe.sv
// riscv_lsu_pipe -- load/store unit for the execute/memory path.
//
// Takes one memory op per handshake from ID/EX, forms the effective address
// (op1 + op2), traps misaligned halfword/word accesses, and drives a single
// in-order data bus. Loads are tracked in a small FIFO so that each returned
// word can be lane-extracted, sign/zero-extended and written back in issue
// order.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_id_ex_rdy / o_id_ex_ack    op handshake
//   i_id_ex_mem_funct            memory function code
//   i_id_ex_op1, i_id_ex_op2     base / offset
//   i_id_ex_mem_data             store data
//   i_id_ex_wb_rsd               load destination register
//   o_data_bif_*                 bus request (req held until i_data_bif_ack)
//   i_data_bif_rdata/_rvalid     in-order read responses
//   o_wb_rf_write/_data/_rsd     register-file writeback (registered)
//   o_lsu_misalign/_addr         misalign pulse and held faulting address
//   o_lsu_rvalid_err             sticky: response with nothing outstanding

`ifndef MEM_FUNCT_W
`define MEM_FUNCT_W 4
`endif
`ifndef MEM_NOP
`define MEM_NOP 0
`endif
`ifndef MEM_LB
`define MEM_LB 1
`endif
`ifndef MEM_LH
`define MEM_LH 2
`endif
`ifndef MEM_LW
`define MEM_LW 3
`endif
`ifndef MEM_LBU
`define MEM_LBU 4
`endif
`ifndef MEM_LHU
`define MEM_LHU 5
`endif
`ifndef MEM_SB
`define MEM_SB 6
`endif
`ifndef MEM_SH
`define MEM_SH 7
`endif
`ifndef MEM_SW
`define MEM_SW 8
`endif

module riscv_lsu_pipe #(
    parameter int LD_DEPTH    = 4,
    parameter int MEM_FUNCT_W = `MEM_FUNCT_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_id_ex_rdy,
    output logic                   o_id_ex_ack,
    input  logic [MEM_FUNCT_W-1:0] i_id_ex_mem_funct,
    input  logic [31:0]            i_id_ex_op1,
    input  logic [31:0]            i_id_ex_op2,
    input  logic [31:0]            i_id_ex_mem_data,
    input  logic [4:0]             i_id_ex_wb_rsd,
    output logic                   o_data_bif_req,
    input  logic                   i_data_bif_ack,
    output logic                   o_data_bif_rnw,
    output logic [31:0]            o_data_bif_addr,
    output logic [3:0]             o_data_bif_wmask,
    output logic [31:0]            o_data_bif_wdata,
    input  logic [31:0]            i_data_bif_rdata,
    input  logic                   i_data_bif_rvalid,
    output logic                   o_wb_rf_write,
    output logic [31:0]            o_wb_rf_data,
    output logic [4:0]             o_wb_rf_rsd,
    output logic                   o_lsu_misalign,
    output logic [31:0]            o_lsu_misalign_addr,
    output logic                   o_lsu_rvalid_err
);

    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [MEM_FUNCT_W-1:0] F_LB  = MEM_FUNCT_W'(`MEM_LB);
    localparam logic [MEM_FUNCT_W-1:0] F_LH  = MEM_FUNCT_W'(`MEM_LH);
    localparam logic [MEM_FUNCT_W-1:0] F_LW  = MEM_FUNCT_W'(`MEM_LW);
    localparam logic [MEM_FUNCT_W-1:0] F_LBU = MEM_FUNCT_W'(`MEM_LBU);
    localparam logic [MEM_FUNCT_W-1:0] F_LHU = MEM_FUNCT_W'(`MEM_LHU);
    localparam logic [MEM_FUNCT_W-1:0] F_SB  = MEM_FUNCT_W'(`MEM_SB);
    localparam logic [MEM_FUNCT_W-1:0] F_SH  = MEM_FUNCT_W'(`MEM_SH);
    localparam logic [MEM_FUNCT_W-1:0] F_SW  = MEM_FUNCT_W'(`MEM_SW);

    // Load tracking FIFO; r_ld_cnt doubles as its occupancy.
    logic [4:0]             r_fifo_rsd   [LD_DEPTH];
    logic [MEM_FUNCT_W-1:0] r_fifo_funct [LD_DEPTH];
    logic [1:0]             r_fifo_off   [LD_DEPTH];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_ld_cnt;

    logic [31:0] w_addr;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misal;
    logic        w_issue;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_ld_data;

    assign w_addr = i_id_ex_op1 + i_id_ex_op2;

    // Held back during reset so every output reads 0 while rst is asserted.
    assign o_id_ex_ack = ~i_rst & (~o_data_bif_req | i_data_bif_ack)
                       & (r_ld_cnt < CW'(LD_DEPTH));
    assign w_accept    = i_id_ex_rdy & o_id_ex_ack;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_misal    = 1'b0;
        w_wmask    = 4'b0000;
        w_wdata    = 32'h0;
        case (i_id_ex_mem_funct)
            F_LB, F_LBU: w_is_load = 1'b1;
            F_LH, F_LHU: begin
                w_is_load = 1'b1;
                w_misal   = w_addr[0];
            end
            F_LW: begin
                w_is_load = 1'b1;
                w_misal   = |w_addr[1:0];
            end
            F_SB: begin
                w_is_store = 1'b1;
                w_wmask    = 4'b0001 << w_addr[1:0];
                w_wdata    = {4{i_id_ex_mem_data[7:0]}};
            end
            F_SH: begin
                w_is_store = 1'b1;
                w_misal    = w_addr[0];
                w_wmask    = 4'b0011 << w_addr[1:0];
                w_wdata    = {2{i_id_ex_mem_data[15:0]}};
            end
            F_SW: begin
                w_is_store = 1'b1;
                w_misal    = |w_addr[1:0];
                w_wmask    = 4'b1111;
                w_wdata    = i_id_ex_mem_data;
            end
            default: ;
        endcase
    end

    assign w_issue = (w_is_load | w_is_store) & ~w_misal;
    assign w_push  = w_accept & w_is_load & ~w_misal;
    // A response can only belong to a load already counted, never to one
    // being pushed in the same cycle.
    assign w_pop   = i_data_bif_rvalid & (r_ld_cnt != '0);

    assign w_lane = i_data_bif_rdata >> {r_fifo_off[r_rptr], 3'b000};

    always_comb begin
        w_ld_data = w_lane;
        case (r_fifo_funct[r_rptr])
            F_LB:    w_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
            F_LBU:   w_ld_data = {24'h0, w_lane[7:0]};
            F_LH:    w_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
            F_LHU:   w_ld_data = {16'h0, w_lane[15:0]};
            default: w_ld_data = w_lane;
        endcase
    end

    // Bus request register: a new issue may replace an acked request in the
    // same cycle, so back-to-back ops see no bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data_bif_req   <= 1'b0;
            o_data_bif_rnw   <= 1'b0;
            o_data_bif_addr  <= 32'h0;
            o_data_bif_wmask <= 4'h0;
            o_data_bif_wdata <= 32'h0;
        end else if (w_accept && w_issue) begin
            o_data_bif_req   <= 1'b1;
            o_data_bif_rnw   <= w_is_load;
            o_data_bif_addr  <= {w_addr[31:2], 2'b00};
            o_data_bif_wmask <= w_wmask;
            o_data_bif_wdata <= w_wdata;
        end else if (i_data_bif_ack) begin
            o_data_bif_req   <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_rsd[r_wptr]   <= i_id_ex_wb_rsd;
            r_fifo_funct[r_wptr] <= i_id_ex_mem_funct;
            r_fifo_off[r_wptr]   <= w_addr[1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_ld_cnt <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_ld_cnt <= r_ld_cnt + 1'b1;
                2'b01:   r_ld_cnt <= r_ld_cnt - 1'b1;
                default: r_ld_cnt <= r_ld_cnt;
            endcase
        end
    end

    // Writeback; x0 destinations still pop but never write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_rf_write <= 1'b0;
            o_wb_rf_data  <= 32'h0;
            o_wb_rf_rsd   <= 5'd0;
        end else begin
            o_wb_rf_write <= w_pop & (r_fifo_rsd[r_rptr] != 5'd0);
            if (w_pop) begin
                o_wb_rf_data <= w_ld_data;
                o_wb_rf_rsd  <= r_fifo_rsd[r_rptr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_lsu_misalign      <= 1'b0;
            o_lsu_misalign_addr <= 32'h0;
            o_lsu_rvalid_err    <= 1'b0;
        end else begin
            o_lsu_misalign <= w_accept & w_misal;
            if (w_accept && w_misal)
                o_lsu_misalign_addr <= w_addr;
            if (i_data_bif_rvalid && r_ld_cnt == '0)
                o_lsu_rvalid_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_lsu_pipe.sv
// Directed bench for riscv_lsu_pipe: inputs change 1 time unit after the
// rising edge, outputs are checked there too, well away from the next edge.
module tb_riscv_lsu_pipe;

    localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3,
                           LBU = 4'd4, LHU = 4'd5, SB = 4'd6, SH = 4'd7,
                           SW = 4'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic        ack;
    logic [3:0]  funct = NOP;
    logic [31:0] op1 = '0, op2 = '0, mdata = '0;
    logic [4:0]  rsd = '0;
    logic        breq, back = 1'b0, brnw, rvalid = 1'b0;
    logic [31:0] baddr, bwdata, rdata = '0;
    logic [3:0]  bwmask;
    logic        wbw;
    logic [31:0] wbd;
    logic [4:0]  wbr;
    logic        mis, rerr;
    logic [31:0] misaddr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_lsu_pipe #(.LD_DEPTH(4), .MEM_FUNCT_W(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_ex_rdy(rdy), .o_id_ex_ack(ack),
        .i_id_ex_mem_funct(funct), .i_id_ex_op1(op1), .i_id_ex_op2(op2),
        .i_id_ex_mem_data(mdata), .i_id_ex_wb_rsd(rsd),
        .o_data_bif_req(breq), .i_data_bif_ack(back), .o_data_bif_rnw(brnw),
        .o_data_bif_addr(baddr), .o_data_bif_wmask(bwmask),
        .o_data_bif_wdata(bwdata), .i_data_bif_rdata(rdata),
        .i_data_bif_rvalid(rvalid),
        .o_wb_rf_write(wbw), .o_wb_rf_data(wbd), .o_wb_rf_rsd(wbr),
        .o_lsu_misalign(mis), .o_lsu_misalign_addr(misaddr),
        .o_lsu_rvalid_err(rerr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op for one cycle; the handshake must be open.
    task automatic issue(input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] d,
                         input logic [4:0] r);
        funct = f; op1 = a; op2 = b; mdata = d; rsd = r; rdy = 1'b1;
        #1;
        chk("issue_ack", {31'd0, ack}, 32'd1);
        tick();
        rdy = 1'b0; funct = NOP;
    endtask

    task automatic resp(input logic [31:0] d);
        rdata = d; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_req", {31'd0, breq}, 32'd0);
        chk("rst_wb", {31'd0, wbw}, 32'd0);
        chk("rst_mis", {31'd0, mis}, 32'd0);
        chk("rst_err", {31'd0, rerr}, 32'd0);
        rst = 1'b0;
        #1;

        // LW 0x1000+4, request held while bus stalls
        issue(LW, 32'h1000, 32'h4, 32'h0, 5'd5);
        chk("lw_req", {31'd0, breq}, 32'd1);
        chk("lw_addr", baddr, 32'h1004);
        chk("lw_rnw", {31'd0, brnw}, 32'd1);
        chk("lw_wmask", {28'd0, bwmask}, 32'd0);
        chk("lw_stall_ack", {31'd0, ack}, 32'd0);
        tick();
        chk("lw_req_held", {31'd0, breq}, 32'd1);
        chk("lw_addr_held", baddr, 32'h1004);
        back = 1'b1;
        tick();
        chk("lw_req_drop", {31'd0, breq}, 32'd0);
        resp(32'hDEADBEEF);
        chk("lw_wb", {31'd0, wbw}, 32'd1);
        chk("lw_wb_data", wbd, 32'hDEADBEEF);
        chk("lw_wb_rsd", {27'd0, wbr}, 32'd5);
        tick();
        chk("lw_wb_pulse", {31'd0, wbw}, 32'd0);

        // Byte / halfword extraction
        issue(LB, 32'h2000, 32'h3, 32'h0, 5'd6);
        resp(32'h80FFFFFF);
        chk("lb_wb_data", wbd, 32'hFFFFFF80);
        chk("lb_wb_rsd", {27'd0, wbr}, 32'd6);
        issue(LBU, 32'h2000, 32'h3, 32'h0, 5'd7);
        resp(32'h80FFFFFF);
        chk("lbu_wb_data", wbd, 32'h00000080);
        issue(LHU, 32'h2000, 32'h2, 32'h0, 5'd8);
        resp(32'hBEEF0000);
        chk("lhu_wb_data", wbd, 32'h0000BEEF);
        issue(LH, 32'h2000, 32'h2, 32'h0, 5'd8);
        resp(32'hBEEF0000);
        chk("lh_wb_data", wbd, 32'hFFFFBEEF);

        // Stores, back to back
        issue(SB, 32'h3000, 32'h1, 32'h12345678, 5'd0);
        chk("sb_req", {31'd0, breq}, 32'd1);
        chk("sb_addr", baddr, 32'h3000);
        chk("sb_rnw", {31'd0, brnw}, 32'd0);
        chk("sb_wmask", {28'd0, bwmask}, 32'h2);
        chk("sb_wdata", bwdata, 32'h78787878);
        issue(SH, 32'h3000, 32'h2, 32'h12345678, 5'd0);
        chk("sh_req", {31'd0, breq}, 32'd1);
        chk("sh_addr", baddr, 32'h3000);
        chk("sh_wmask", {28'd0, bwmask}, 32'hC);
        chk("sh_wdata", bwdata, 32'h56785678);

        // Misaligned LW then a normal SW
        issue(LW, 32'h4000, 32'h2, 32'h0, 5'd9);
        chk("mis_noreq", {31'd0, breq}, 32'd0);
        chk("mis_pulse", {31'd0, mis}, 32'd1);
        chk("mis_addr", misaddr, 32'h4002);
        issue(SW, 32'h4000, 32'h0, 32'hCAFEF00D, 5'd0);
        chk("mis_pulse_end", {31'd0, mis}, 32'd0);
        chk("mis_addr_held", misaddr, 32'h4002);
        chk("sw_req", {31'd0, breq}, 32'd1);
        chk("sw_addr", baddr, 32'h4000);
        chk("sw_wmask", {28'd0, bwmask}, 32'hF);
        chk("sw_wdata", bwdata, 32'hCAFEF00D);

        // Outstanding-load limit and in-order writeback
        for (int i = 0; i < 4; i++)
            issue(LW, 32'h5000, 32'(4 * i), 32'h0, 5'(i + 1));
        funct = LW; op1 = 32'h5010; op2 = 32'h0; rsd = 5'd9; rdy = 1'b1;
        #1;
        chk("full_ack", {31'd0, ack}, 32'd0);
        tick();
        chk("full_ack_hold", {31'd0, ack}, 32'd0);
        rdata = 32'h11111111; rvalid = 1'b1;
        #1;
        chk("full_ack_rvalid", {31'd0, ack}, 32'd0);
        tick();
        rvalid = 1'b0;
        chk("full_ack_rise", {31'd0, ack}, 32'd1);
        chk("ord_rsd1", {27'd0, wbr}, 32'd1);
        chk("ord_data1", wbd, 32'h11111111);
        tick();
        rdy = 1'b0; funct = NOP;
        chk("fifth_addr", baddr, 32'h5010);
        resp(32'h22222222);
        chk("ord_rsd2", {27'd0, wbr}, 32'd2);
        chk("ord_data2", wbd, 32'h22222222);
        resp(32'h33333333);
        chk("ord_rsd3", {27'd0, wbr}, 32'd3);
        resp(32'h44444444);
        chk("ord_rsd4", {27'd0, wbr}, 32'd4);
        resp(32'h55555555);
        chk("ord_rsd9", {27'd0, wbr}, 32'd9);
        chk("ord_data9", wbd, 32'h55555555);

        // Stray response, x0 destination
        chk("err_before", {31'd0, rerr}, 32'd0);
        resp(32'h66666666);
        chk("stray_nowb", {31'd0, wbw}, 32'd0);
        chk("stray_err", {31'd0, rerr}, 32'd1);
        issue(LW, 32'h6000, 32'h0, 32'h0, 5'd0);
        resp(32'h77777777);
        chk("x0_nowb", {31'd0, wbw}, 32'd0);
        chk("err_sticky", {31'd0, rerr}, 32'd1);

        // Reset with a load in flight; its late response is an error
        issue(LW, 32'h7000, 32'h0, 32'h0, 5'd7);
        rst = 1'b1;
        tick();
        chk("mrst_req", {31'd0, breq}, 32'd0);
        chk("mrst_err", {31'd0, rerr}, 32'd0);
        chk("mrst_misaddr", misaddr, 32'h0);
        chk("mrst_wb", {31'd0, wbw}, 32'd0);
        rst = 1'b0;
        resp(32'h88888888);
        chk("mrst_late_nowb", {31'd0, wbw}, 32'd0);
        chk("mrst_late_err", {31'd0, rerr}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_lsu_pipe.md
# riscv_lsu_pipe

Parametrised load/store unit for the RISC-V core's execute/memory path. Accepts memory operations from the ID/EX handshake, computes and checks the effective address, issues requests on the data bus interface (data_bif), and tracks up to LD_DEPTH outstanding loads. Load data is byte-lane extracted, sign/zero-extended and written back to the register file in issue order. Misaligned accesses are trapped instead of issued.

## Interface
- LD_DEPTH, 4: maximum outstanding loads (issued, rvalid not yet returned); power of two, ≥2.
- MEM_FUNCT_W, `MEM_FUNCT_W: width of the memory function code (`MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- id_ex_rdy  in  1  operation valid.
- id_ex_ack  out  1  operation accepted this cycle when id_ex_rdy && id_ex_ack.
- id_ex_mem_funct  in  MEM_FUNCT_W  memory function.
- id_ex_op1, id_ex_op2  in  32  address operands (base, offset).
- id_ex_mem_data  in  32  store data.
- id_ex_wb_rsd  in  5  load destination register.
- data_bif_req  out  1  bus request, held until data_bif_ack.
- data_bif_ack  in  1  request accepted.
- data_bif_rnw  out  1  1 = read.
- data_bif_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- data_bif_wmask  out  4  byte write enables.
- data_bif_wdata  out  32  lane-replicated store data.
- data_bif_rdata  in  32  read data, valid with rvalid.
- data_bif_rvalid  in  1  read response, in request order.
- wb_rf_write  out  1  register write pulse.
- wb_rf_data  out  32  write data.
- wb_rf_rsd  out  5  destination register.
- lsu_misalign  out  1  one-cycle pulse: misaligned op dropped.
- lsu_misalign_addr  out  32  offending effective address (held until next misalign).
- lsu_rvalid_err  out  1  sticky: rvalid arrived with no outstanding load.

## Operation
- Effective address A = op1 + op2 (mod 2^32).
- Accept: id_ex_ack = (~data_bif_req | data_bif_ack) & (ld_cnt < LD_DEPTH). ld_cnt counts loads issued/pending minus rvalids.
- MEM_NOP: accepted, no effect.
- Alignment: LH/LHU/SH require A[0]=0; LW/SW require A[1:0]=0. Violation: no request, no FIFO push, lsu_misalign=1 next cycle, lsu_misalign_addr=A.
- Aligned op: request register loads next cycle: rnw, addr, wmask, wdata. Stores: SB mask 4'b0001<<A[1:0], wdata {4{d[7:0]}}; SH 4'b0011<<A[1:0], {2{d[15:0]}}; SW 4'b1111, d. Loads: wmask 0, wdata 0.
- Load accept pushes {rsd, funct, A[1:0]} into tracking FIFO (depth LD_DEPTH); ld_cnt increments at accept.
- rvalid pops FIFO head: lane = rdata >> (8*A[1:0]); LB sext 8, LBU zext 8, LH sext 16, LHU zext 16, LW whole word.
- Writeback suppressed (wb_rf_write=0) when rsd = 0; FIFO still pops.
- rvalid with FIFO empty: ignored, lsu_rvalid_err set until rst.
- Simultaneous push and pop: both occur, ld_cnt unchanged.
- Stores and loads share the single in-order bus; no reordering.

## Timing
- Reset (rst high at posedge): all outputs 0, FIFO empty, ld_cnt 0, request register cleared; in-flight responses after reset are counted as errors only if they arrive once rst is low.
- Accept in cycle N → data_bif_req high from N+1, held with stable addr/wmask/wdata/rnw until data_bif_ack.
- Back-to-back: ack in cycle M and new accept in M → next request in M+1, no bubble.
- rvalid in cycle R → wb_rf_write pulse in R+1 (registered data/rsd).
- Misaligned accept in N → lsu_misalign pulse in N+1 only.
- ld_cnt == LD_DEPTH → id_ex_ack 0 for all ops until an rvalid arrives; ack rises the cycle after that rvalid.

## Test plan
- LW op1=0x1000, op2=0x4; rdata 0xDEADBEEF after ack → req addr 0x1004 rnw=1; wb_rf_write next cycle after rvalid, data 0xDEADBEEF, rsd as given.
- LB A=0x2003, rdata 0x80FF_FFFF → wb 0xFFFFFF80; LBU same → 0x00000080; LHU A=0x2002, rdata 0xBEEF_0000 → 0x0000BEEF.
- SB A=0x3001, data 0x12345678 → wmask 0x2, wdata 0x78787878, addr 0x3000; SH A=0x3002 → wmask 0xC, wdata 0x56785678.
- LW A=0x4002 → no req, lsu_misalign pulse, lsu_misalign_addr 0x4002; following SW A=0x4000 issues normally.
- LD_DEPTH=4, ack tied 1, rvalid held off: 4 loads accepted, 5th stalls id_ex_ack=0; one rvalid → ack rises next cycle; responses write back in issue order.
- rvalid with no load outstanding → lsu_rvalid_err=1, no wb; load with rsd=0 → no wb_rf_write; rst mid-stream → outputs 0, FIFO empty.
